memory_arbiter: RTL and testbench

- Round-robin arbiter for the single shared memory port of the coprocessor.
- Requester 0 is the main control unit (config reads, status writes); requesters 1..p are the p processing units.
- Grants exactly one requester at a time, holds the grant until it is released, and inserts one bus-turnaround cycle between owners.
- Drives the memory address/data mux select and the o_Grant lines back to the requesters.

---
 rtl/memory_arbiter.sv | 121 ++++++++++++
 tb/tb_memory_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Round-robin arbiter for the shared memory port: one owner at a time, grant held until
// release, one dead turnaround cycle between owners. Define ARB_TIMEOUT_EN to enable the hold limit.
module memory_arbiter #(
  parameter int p        = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic [p:0]                  i_Request,
  output logic [p:0]                  o_Grant,
  output logic [$clog2(p+1)-1:0]      o_Grant_Index,
  output logic                        o_Busy,
  output logic                        o_Timeout
);
  localparam int N  = p + 1;
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_TURNAROUND} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            busy_q, busy_d;
  logic            tmo_q, tmo_d;

  logic            found;
  logic [IW-1:0]   pick;
  logic [IW:0]     cand;
  logic [IW-1:0]   next_ptr;

  // First requester at or after the pointer, searching upward modulo N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && i_Request[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  assign next_ptr = (idx_q == IW'(N-1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = N'(1) << pick;
          idx_d   = pick;
          busy_d  = 1'b1;
          hold_d  = '0;
          state_d = S_GRANTED;
        end
      end
      S_GRANTED: begin
        hold_d = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
        if (!i_Request[idx_q]) begin
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = next_ptr;
          state_d = S_TURNAROUND;
        end
`ifdef ARB_TIMEOUT_EN
        // Revoke on the edge where the counter reaches MAX_HOLD: grant was high MAX_HOLD cycles.
        else if (hold_q == HW'(MAX_HOLD-1)) begin
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = next_ptr;
          tmo_d   = 1'b1;
          state_d = S_TURNAROUND;
        end
`endif
      end
      S_TURNAROUND: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_Grant       = grant_q;
  assign o_Grant_Index = idx_q;
  assign o_Busy        = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign o_Timeout     = tmo_q;
`else
  assign o_Timeout     = 1'b0;
`endif
endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized and directed bench for memory_arbiter against an abstract owner/pointer model.
module tb_memory_arbiter;
  localparam int P    = 4;
  localparam int N    = P + 1;
  localparam int IW   = $clog2(N);
  localparam int MAXH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  o_Grant;
  logic [IW-1:0] o_Grant_Index;
  logic          o_Busy, o_Timeout;

  int checks = 0;
  int failures = 0;

  // Model: who owns the port, where the search starts, and bookkeeping for turnaround/hold.
  int m_own = -1, m_ptr = 0, m_last = 0, m_held = 0;
  bit m_turn = 0, m_tmo = 0;

  memory_arbiter #(.p(P), .MAX_HOLD(MAXH)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Request(req),
    .o_Grant(o_Grant), .o_Grant_Index(o_Grant_Index),
    .o_Busy(o_Busy), .o_Timeout(o_Timeout)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic r, input logic [N-1:0] q);
    m_tmo = 0;
    if (r) begin
      m_own = -1; m_ptr = 0; m_last = 0; m_held = 0; m_turn = 0;
    end else if (m_own >= 0) begin
      if (!q[m_own]) begin
        m_ptr = (m_own + 1) % N; m_own = -1; m_turn = 1;
      end else begin
        m_held++;
`ifdef ARB_TIMEOUT_EN
        if (m_held == MAXH) begin
          m_ptr = (m_own + 1) % N; m_own = -1; m_turn = 1; m_tmo = 1;
        end
`endif
      end
    end else if (m_turn) begin
      m_turn = 0;
    end else if (q != 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_own < 0 && q[c]) m_own = c;
      end
      m_last = m_own; m_held = 0;
    end
  endtask

  function automatic logic [N+IW+1:0] exp_vec();
    logic [N-1:0] g;
    g = (m_own >= 0) ? (N'(1) << m_own) : '0;
    return {g, IW'(m_last), (m_own >= 0), m_tmo};
  endfunction

  task automatic step(input logic r, input logic [N-1:0] q);
    rst = r; req = q;
    @(posedge clk);
    model_edge(r, q);
    #1;
  endtask

  task automatic test_reset();
    step(1, '1);
    step(1, '1);
    checks++;
    if ({o_Grant, o_Busy, o_Timeout} !== '0) begin
      failures++; $display("FAIL reset_state got=%b/%b/%b want=0/0/0", o_Grant, o_Busy, o_Timeout);
    end
    step(0, '1);
    checks++;
    if (o_Grant !== 5'b00001 || o_Grant_Index !== 0) begin
      failures++; $display("FAIL reset_first_grant got=%b idx=%0d want=00001 idx=0", o_Grant, o_Grant_Index);
    end
  endtask

  task automatic test_latency();
    step(1, '0);
    step(0, 5'b00110);
    checks++;
    if (o_Grant !== 5'b00010 || o_Grant_Index !== 1 || o_Busy !== 1'b1) begin
      failures++; $display("FAIL latency_grant got=%b idx=%0d want=00010 idx=1", o_Grant, o_Grant_Index);
    end
    step(0, 5'b00100);
    checks++;
    if (o_Grant !== '0 || o_Busy !== 1'b0 || o_Grant_Index !== 1) begin
      failures++; $display("FAIL latency_release got=%b busy=%b idx=%0d want=0 0 1", o_Grant, o_Busy, o_Grant_Index);
    end
    step(0, 5'b00100);
    checks++;
    if (o_Grant !== '0) begin
      failures++; $display("FAIL latency_turnaround got=%b want=00000", o_Grant);
    end
    step(0, 5'b00100);
    checks++;
    if (o_Grant !== 5'b00100 || o_Grant_Index !== 2) begin
      failures++; $display("FAIL latency_regrant got=%b want=00100", o_Grant);
    end
  endtask

  task automatic test_rr_wrap();
    int exp_order[7] = '{0, 1, 2, 3, 4, 0, 1};
    int n = 0, cnt = 0;
    logic [N-1:0] prevg = '0, r;
    step(1, '0);
    for (int cyc = 0; cyc < 80 && n < 7; cyc++) begin
      r = '1;
      if (o_Grant != 0 && cnt == 3) r = r & ~o_Grant;
      step(0, r);
      checks++;
      if ({o_Grant, o_Grant_Index, o_Busy, o_Timeout} !== exp_vec()) begin
        failures++; $display("FAIL rr_model got=%h want=%h", {o_Grant, o_Grant_Index, o_Busy, o_Timeout}, exp_vec());
      end
      if (o_Grant != 0 && prevg == 0) begin
        checks++;
        if (o_Grant !== (N'(1) << exp_order[n])) begin
          failures++; $display("FAIL rr_order[%0d] got=%b want owner %0d", n, o_Grant, exp_order[n]);
        end
        n++; cnt = 1;
      end else if (o_Grant != 0) begin
        if (o_Grant != prevg) begin
          checks++; failures++;
          $display("FAIL rr_no_gap got=%b prev=%b want a zero cycle between", o_Grant, prevg);
        end
        cnt++;
      end
      prevg = o_Grant;
    end
    checks++;
    if (n != 7) begin
      failures++; $display("FAIL rr_count got=%0d want=7", n);
    end
  endtask

  task automatic test_noise();
    step(1, '0);
    step(0, 5'b00100);
    for (int i = 0; i < 12; i++) begin
      step(0, N'($urandom) | 5'b00100);
      checks++;
      if (o_Grant !== 5'b00100 || o_Grant_Index !== 2 || o_Busy !== 1'b1) begin
        failures++; $display("FAIL noise got=%b idx=%0d want=00100 idx=2", o_Grant, o_Grant_Index);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, '0);
    step(0, 5'b01000);
    step(0, 5'b11111);
    checks++;
    if (o_Grant !== 5'b01000) begin
      failures++; $display("FAIL midrst_owner got=%b want=01000", o_Grant);
    end
    step(1, 5'b11111);
    checks++;
    if (o_Grant !== '0 || o_Busy !== 1'b0 || o_Grant_Index !== 0) begin
      failures++; $display("FAIL midrst_drop got=%b idx=%0d want=00000 idx=0", o_Grant, o_Grant_Index);
    end
    step(0, 5'b11111);
    checks++;
    if (o_Grant !== 5'b00001) begin
      failures++; $display("FAIL midrst_regrant got=%b want=00001", o_Grant);
    end
  endtask

  task automatic test_hold_limit();
    step(1, '0);
    step(0, 5'b00010);
    for (int i = 1; i <= 12; i++) begin
      step(0, 5'b00110);
`ifdef ARB_TIMEOUT_EN
      if (i < 8) begin
        checks++;
        if (o_Grant !== 5'b00010 || o_Timeout !== 1'b0) begin
          failures++; $display("FAIL tmo_hold[%0d] got=%b tmo=%b want=00010 0", i, o_Grant, o_Timeout);
        end
      end else if (i == 8) begin
        checks++;
        if (o_Grant !== '0 || o_Timeout !== 1'b1 || o_Busy !== 1'b0) begin
          failures++; $display("FAIL tmo_revoke got=%b tmo=%b want=00000 1", o_Grant, o_Timeout);
        end
      end else if (i == 9) begin
        checks++;
        if (o_Grant !== '0 || o_Timeout !== 1'b0) begin
          failures++; $display("FAIL tmo_pulse got=%b tmo=%b want=00000 0", o_Grant, o_Timeout);
        end
      end else if (i == 10) begin
        checks++;
        if (o_Grant !== 5'b00100) begin
          failures++; $display("FAIL tmo_next got=%b want=00100", o_Grant);
        end
      end
`else
      checks++;
      if (o_Grant !== 5'b00010 || o_Timeout !== 1'b0) begin
        failures++; $display("FAIL hold_forever[%0d] got=%b tmo=%b want=00010 0", i, o_Grant, o_Timeout);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    step(1, '0);
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      step($urandom_range(0, 60) == 0, r);
      checks++;
      if ({o_Grant, o_Grant_Index, o_Busy, o_Timeout} !== exp_vec() || $countones(o_Grant) > 1) begin
        failures++; $display("FAIL random[%0d] got=%h want=%h", i, {o_Grant, o_Grant_Index, o_Busy, o_Timeout}, exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = '0;
    test_reset();
    test_latency();
    test_rr_wrap();
    test_noise();
    test_reset_mid();
    test_hold_limit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
